// File: rtl/ascii_to_hid_pkg.sv
// ascii_to_hid_pkg: FSM states, HID usage constants and the ASCII-to-HID mapping function.
// Macro ASCII_TO_HID_SHIFT_EN: when defined, uppercase letters and shifted symbols
// map with the left-shift modifier; otherwise uppercase folds to lowercase and
// shifted symbols are unmapped.
package ascii_to_hid_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LOOKUP = 2'd1;
    localparam state_t ST_FIRE   = 2'd2;
    localparam state_t ST_GAP    = 2'd3;

    localparam logic [7:0] HID_A         = 8'h04;
    localparam logic [7:0] HID_1         = 8'h1E;
    localparam logic [7:0] HID_0         = 8'h27;
    localparam logic [7:0] HID_ENTER     = 8'h28;
    localparam logic [7:0] HID_BACKSPACE = 8'h2A;
    localparam logic [7:0] HID_TAB       = 8'h2B;
    localparam logic [7:0] HID_SPACE     = 8'h2C;
    localparam logic [7:0] HID_MINUS     = 8'h2D;
    localparam logic [7:0] HID_EQUAL     = 8'h2E;
    localparam logic [7:0] HID_LBRACKET  = 8'h2F;
    localparam logic [7:0] HID_RBRACKET  = 8'h30;
    localparam logic [7:0] HID_BACKSLASH = 8'h31;
    localparam logic [7:0] HID_SEMICOLON = 8'h33;
    localparam logic [7:0] HID_QUOTE     = 8'h34;
    localparam logic [7:0] HID_GRAVE     = 8'h35;
    localparam logic [7:0] HID_COMMA     = 8'h36;
    localparam logic [7:0] HID_PERIOD    = 8'h37;
    localparam logic [7:0] HID_SLASH     = 8'h38;

    localparam logic [7:0] MOD_NONE   = 8'h00;
    localparam logic [7:0] MOD_LSHIFT = 8'h02;
`ifdef ASCII_TO_HID_SHIFT_EN
    localparam logic [7:0] MOD_UPPER = MOD_LSHIFT;
`else
    localparam logic [7:0] MOD_UPPER = MOD_NONE;
`endif

    // Returns {mapped, modifier[7:0], usage[7:0]}.
    function automatic logic [16:0] ascii2hid(input logic [7:0] c);
        logic       ok;
        logic [7:0] md;
        logic [7:0] code;
        ok   = 1'b1;
        md   = MOD_NONE;
        code = 8'h00;
        if (c inside {[8'h61:8'h7A]}) code = HID_A + (c - 8'h61);
        else if (c inside {[8'h41:8'h5A]}) {md, code} = {MOD_UPPER, 8'(HID_A + (c - 8'h41))};
        else if (c inside {[8'h31:8'h39]}) code = HID_1 + (c - 8'h31);
        else begin
            case (c)
                8'h30:        code = HID_0;
                8'h0A, 8'h0D: code = HID_ENTER;
                8'h08:        code = HID_BACKSPACE;
                8'h09:        code = HID_TAB;
                8'h20:        code = HID_SPACE;
                8'h2D:        code = HID_MINUS;
                8'h3D:        code = HID_EQUAL;
                8'h5B:        code = HID_LBRACKET;
                8'h5D:        code = HID_RBRACKET;
                8'h5C:        code = HID_BACKSLASH;
                8'h3B:        code = HID_SEMICOLON;
                8'h27:        code = HID_QUOTE;
                8'h60:        code = HID_GRAVE;
                8'h2C:        code = HID_COMMA;
                8'h2E:        code = HID_PERIOD;
                8'h2F:        code = HID_SLASH;
`ifdef ASCII_TO_HID_SHIFT_EN
                8'h21:        {md, code} = {MOD_LSHIFT, 8'h1E};
                8'h40:        {md, code} = {MOD_LSHIFT, 8'h1F};
                8'h23:        {md, code} = {MOD_LSHIFT, 8'h20};
                8'h24:        {md, code} = {MOD_LSHIFT, 8'h21};
                8'h25:        {md, code} = {MOD_LSHIFT, 8'h22};
                8'h5E:        {md, code} = {MOD_LSHIFT, 8'h23};
                8'h26:        {md, code} = {MOD_LSHIFT, 8'h24};
                8'h2A:        {md, code} = {MOD_LSHIFT, 8'h25};
                8'h28:        {md, code} = {MOD_LSHIFT, 8'h26};
                8'h29:        {md, code} = {MOD_LSHIFT, HID_0};
                8'h5F:        {md, code} = {MOD_LSHIFT, HID_MINUS};
                8'h2B:        {md, code} = {MOD_LSHIFT, HID_EQUAL};
                8'h7B:        {md, code} = {MOD_LSHIFT, HID_LBRACKET};
                8'h7D:        {md, code} = {MOD_LSHIFT, HID_RBRACKET};
                8'h7C:        {md, code} = {MOD_LSHIFT, HID_BACKSLASH};
                8'h3A:        {md, code} = {MOD_LSHIFT, HID_SEMICOLON};
                8'h22:        {md, code} = {MOD_LSHIFT, HID_QUOTE};
                8'h7E:        {md, code} = {MOD_LSHIFT, HID_GRAVE};
                8'h3C:        {md, code} = {MOD_LSHIFT, HID_COMMA};
                8'h3E:        {md, code} = {MOD_LSHIFT, HID_PERIOD};
                8'h3F:        {md, code} = {MOD_LSHIFT, HID_SLASH};
`endif
                default:      ok = 1'b0;
            endcase
        end
        return {ok, md, code};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags and a combinational head output.
// Ports: clk, rst (sync active-high), wr_en/wr_data push, rd_en pop,
// rd_data = current head entry, full, empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    // A pop frees the head slot in the same edge, so push-while-full is accepted when popping.
    assign do_wr   = wr_en && (!full || rd_en);
    assign do_rd   = rd_en && !empty;
    assign full    = count == FULL_CNT;
    assign empty   = count == '0;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
        end
    end

endmodule

// File: rtl/ascii_to_hid_keys.sv
// ascii_to_hid_keys: buffers an ASCII stream and types it as paced HID key requests.
// Ports: clk, rst (sync active-high); in_data/in_valid/in_ready byte input;
// key_value {modifier, usage} with one-cycle key_request pulse; busy; drop_count
// (saturating count of unmapped bytes). Macro ASCII_TO_HID_SHIFT_EN enables
// shifted characters (see ascii_to_hid_pkg).
module ascii_to_hid_keys
    import ascii_to_hid_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int PACE_CYCLES = 6000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] key_value,
    output logic        key_request,
    output logic        busy,
    output logic [7:0]  drop_count
);

    localparam int GW = $clog2(PACE_CYCLES);
    // FIRE-to-FIRE spacing is FIRE + GAP + IDLE + LOOKUP, so GAP lasts PACE_CYCLES-3 cycles.
    localparam logic [GW-1:0] GAP_LOAD = GW'(PACE_CYCLES - 3);

    state_t         state;
    logic [7:0]     hold;
    logic [15:0]    next_value;
    logic           cr_sup;
    logic [GW-1:0]  gap_cnt;
    logic [7:0]     head;
    logic [16:0]    map;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;

    assign in_ready = !fifo_full && !rst;
    assign pop      = (state == ST_IDLE) && !fifo_empty;
    assign map      = ascii2hid(hold);
    assign busy     = !fifo_empty || (state != ST_IDLE);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid && in_ready),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            hold        <= 8'h00;
            next_value  <= 16'h0000;
            cr_sup      <= 1'b0;
            gap_cnt     <= '0;
            key_value   <= 16'h0000;
            key_request <= 1'b0;
            drop_count  <= 8'h00;
        end else begin
            key_request <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        hold  <= head;
                        state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    next_value <= map[15:0];
                    if (!map[16]) begin
                        drop_count <= drop_count + {7'd0, drop_count != 8'hFF};
                        state      <= ST_IDLE;
                    end else if (hold == 8'h0A && cr_sup) begin
                        // LF directly after CR was already typed as Enter.
                        cr_sup <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        state <= ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    key_value   <= next_value;
                    key_request <= 1'b1;
                    cr_sup      <= hold == 8'h0D;
                    gap_cnt     <= GAP_LOAD;
                    state       <= ST_GAP;
                end
                default: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    state   <= (gap_cnt == GW'(1)) ? ST_IDLE : ST_GAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_to_hid_keys.sv
// tb_ascii_to_hid_keys: directed and random byte streams checked against a table-driven typing model.
module tb_ascii_to_hid_keys;
  localparam int PACE  = 8;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] key_value;
  logic        key_request;
  logic        busy;
  logic [7:0]  drop_count;
  always #5 clk = ~clk;
  ascii_to_hid_keys #(.FIFO_DEPTH(DEPTH), .PACE_CYCLES(PACE)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .key_value   (key_value),
    .key_request (key_request),
    .busy        (busy),
    .drop_count  (drop_count)
  );
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [15:0] got_v[$];
  int          got_c[$];
  always @(negedge clk) begin
    if (key_request === 1'b1) begin
      got_v.push_back(key_value);
      got_c.push_back(cyc);
    end
  end
  logic [15:0] ref_map [256];
  bit          ref_ok  [256];
  logic [7:0]  sy_code [11] = '{8'h2D, 8'h2E, 8'h2F, 8'h30, 8'h31, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
  logic [7:0]  sy_chr  [11] = '{8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h60, 8'h2C, 8'h2E, 8'h2F};
  logic [7:0]  sh_chr  [11] = '{8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h7E, 8'h3C, 8'h3E, 8'h3F};
  logic [15:0] exp_q[$];
  bit          m_cr = 1'b0;
  int          m_drop = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          saw_stall = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic set_map(input logic [7:0] c, input logic [15:0] v);
    ref_ok[c]  = 1'b1;
    ref_map[c] = v;
  endtask
  task automatic build_map();
    string lo, dg;
    lo = "abcdefghijklmnopqrstuvwxyz1234567890";
    dg = "!@#$%^&*()";
    for (int i = 0; i < 256; i++) begin
      ref_ok[i]  = 1'b0;
      ref_map[i] = 16'h0000;
    end
    for (int i = 0; i < 36; i++) set_map(lo[i], 16'(4 + i));
    set_map(8'h0D, 16'h0028);
    set_map(8'h0A, 16'h0028);
    set_map(8'h08, 16'h002A);
    set_map(8'h09, 16'h002B);
    set_map(8'h20, 16'h002C);
    for (int i = 0; i < 11; i++) set_map(sy_chr[i], {8'h00, sy_code[i]});
`ifdef ASCII_TO_HID_SHIFT_EN
    for (int i = 0; i < 26; i++) set_map(8'(8'h41 + i), 16'h0200 + 16'(4 + i));
    for (int i = 0; i < 10; i++) set_map(dg[i], 16'h0200 + 16'(8'h1E + i));
    for (int i = 0; i < 11; i++) set_map(sh_chr[i], {8'h02, sy_code[i]});
`else
    for (int i = 0; i < 26; i++) set_map(8'(8'h41 + i), 16'(4 + i));
`endif
  endtask
  task automatic model_push(input logic [7:0] b);
    if (!ref_ok[b]) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
    else if (b == 8'h0A && m_cr) m_cr = 1'b0;
    else begin
      exp_q.push_back(ref_map[b]);
      m_cr = (b == 8'h0D);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input logic [7:0] b, output int acc);
    int w;
    w = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && w < 500) begin
      saw_stall = 1'b1;
      tick(1);
      w++;
    end
    if (w == 500) chk("push_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    acc      = cyc;
    in_valid = 1'b0;
    model_push(b);
  endtask
  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 5000) begin
      tick(1);
      w++;
    end
    if (busy) chk("idle_timeout", busy, 1'b0);
  endtask
  task automatic compare(input string tag);
    wait_idle();
    chk({tag, "_count"}, got_v.size(), exp_q.size());
    for (int i = 0; i < got_v.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_val%0d", tag, i), got_v[i], exp_q[i]);
    for (int i = 1; i < got_c.size(); i++)
      chk($sformatf("%s_pace%0d", tag, i), (got_c[i] - got_c[i-1]) >= PACE, 1'b1);
    chk({tag, "_drop"}, drop_count, m_drop);
  endtask
  task automatic flush();
    got_v.delete();
    got_c.delete();
    exp_q.delete();
  endtask
  initial begin
    int t0, t, w;
    logic [7:0] b;
    build_map();
    tick(3);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_key_value", key_value, 16'h0000);
    chk("rst_key_request", key_request, 1'b0);
    chk("rst_drop", drop_count, 8'h00);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick(1);
    chk("ready_after_rst", in_ready, 1'b1);
    push(8'h61, t0);
    compare("a");
    chk("a_value", (got_v.size() > 0) ? got_v[0] : 16'hFFFF, 16'h0004);
    chk("a_latency", (got_c.size() > 0) ? got_c[0] - t0 : -1, 3);
    chk("a_busy_after", busy, 1'b0);
    flush();
    push(8'h68, t0);
    push(8'h69, t);
    push(8'h39, t);
    compare("hi9");
    if (got_c.size() == 3) begin
      chk("hi9_t0", got_c[0] - t0, 3);
      chk("hi9_t1", got_c[1] - t0, 3 + PACE);
      chk("hi9_t2", got_c[2] - t0, 3 + 2 * PACE);
      chk("hi9_v2", got_v[2], 16'h0026);
    end
    flush();
    push(8'h0D, t);
    push(8'h0A, t);
    push(8'h0A, t);
    compare("crlf");
    chk("crlf_pulses", got_v.size(), 2);
    flush();
    push(8'h01, t);
    push(8'h80, t);
    push(8'h78, t);
    compare("drops");
    chk("drops_two", drop_count, 8'd2);
    chk("drops_x", (got_v.size() > 0) ? got_v[0] : 16'hFFFF, 16'h001B);
    flush();
    push(8'h41, t);
    push(8'h21, t);
    compare("shift");
`ifdef ASCII_TO_HID_SHIFT_EN
    chk("shift_pulses", got_v.size(), 2);
    chk("shift_A", (got_v.size() > 0) ? got_v[0] : 16'hFFFF, 16'h0204);
`else
    chk("shift_pulses", got_v.size(), 1);
    chk("shift_A", (got_v.size() > 0) ? got_v[0] : 16'hFFFF, 16'h0004);
    chk("shift_drop", drop_count, 8'd3);
`endif
    flush();
    saw_stall = 1'b0;
    for (int i = 0; i < 10; i++) push(8'(8'h61 + $urandom_range(0, 25)), t);
    compare("flow");
    chk("flow_stall", saw_stall, 1'b1);
    flush();
    for (int i = 0; i < 60; i++) begin
      b = 8'($urandom_range(0, 255));
      w = 0;
      if ($urandom_range(0, 1) == 1)
        while (!ref_ok[b] && w < 1000) begin
          b = 8'($urandom_range(0, 255));
          w++;
        end
      push(b, t);
      tick($urandom_range(0, 3));
    end
    compare("random");
    flush();
    for (int i = 0; i < 300; i++) push(8'h01, t);
    compare("sat");
    chk("sat_255", drop_count, 8'd255);
    flush();
    push(8'h62, t);
    push(8'h63, t);
    w = 0;
    while (got_v.size() == 0 && w < 100) begin
      tick(1);
      w++;
    end
    chk("gap_pulse_seen", got_v.size(), 1);
    tick(2);
    rst = 1'b1;
    #1;
    chk("gap_rst_ready", in_ready, 1'b0);
    tick(1);
    chk("gap_rst_ready2", in_ready, 1'b0);
    rst = 1'b0;
    m_cr = 1'b0;
    m_drop = 0;
    tick(4 * PACE);
    chk("gap_rst_pulses", got_v.size(), 1);
    chk("gap_rst_b", (got_v.size() > 0) ? got_v[0] : 16'hFFFF, 16'h0005);
    chk("gap_rst_key_value", key_value, 16'h0000);
    chk("gap_rst_busy", busy, 1'b0);
    chk("gap_rst_drop", drop_count, 8'h00);
    flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
